// File: rtl/uds_out_serializer.sv
// Frame buffer and beat serializer behind the UDS engine: captures whole result
// vectors, streams their valid words as BEAT-word beats, and counts frames to finish.
module uds_out_serializer #(
  parameter int A     = 64,
  parameter int DW    = 32,
  parameter int BEAT  = 8,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active,
  input  logic [15:0]           frame_total,
  input  logic [1:0]            function_mode,
  input  logic [1:0]            scale_factor,
  input  logic [2*A*DW-1:0]     odata,
  input  logic                  odata_valid,
  output logic [BEAT*DW-1:0]    m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  buf_full,
  output logic                  overflow,
  output logic                  finish
);

  localparam int FW     = 2 * A * DW;
  localparam int BW     = BEAT * DW;
  localparam int NB_MAX = 2 * A / BEAT;
  localparam int NBW    = $clog2(NB_MAX + 1);
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);

  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [NBW-1:0] NB_UP    = NBW'(NB_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t r_state;
  state_t w_state_next;

  logic [FW-1:0]  r_slot    [DEPTH];
  logic [NBW-1:0] r_slot_nb [DEPTH];

  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [NBW-1:0] r_beat_idx;
  logic [15:0]    r_frame_total;
  logic [15:0]    r_frames_out;
  logic           r_overflow;

  logic           w_start;
  logic           w_xfer;
  logic           w_last_beat;
  logic           w_retire;
  logic           w_push;
  logic           w_drop;
  logic           w_job_done;
  logic [NBW-1:0] w_nb_in;
  logic [NBW-1:0] w_cur_nb;
  logic [BW-1:0]  w_beat;

  // Beats per frame are fixed at capture so later mode changes cannot affect a buffered frame.
  always_comb begin
    // NOTE: assign a default before any branch so the combinational block never infers a latch.
    w_nb_in = NB_UP;
    if (function_mode[0]) w_nb_in = NBW'((A >> scale_factor) / BEAT);
  end

  assign w_cur_nb    = r_slot_nb[r_rptr];
  assign w_last_beat = (r_beat_idx == w_cur_nb - NBW'(1));
  assign w_beat      = r_slot[r_rptr][int'(r_beat_idx) * BW +: BW];

  assign m_valid  = (r_state == RUN) && (r_count != '0);
  assign m_last   = m_valid && w_last_beat;
  assign m_data   = m_valid ? w_beat : '0;
  assign buf_full = (r_count == FULL_CNT);
  assign overflow = r_overflow;
  assign finish   = (r_state == DONE);

  assign w_xfer     = m_valid && m_ready;
  assign w_retire   = w_xfer && w_last_beat;
  assign w_start    = active && (r_state != RUN);
  // A retiring frame frees its slot in the same cycle, so a full buffer can still accept.
  assign w_push     = (r_state == RUN) && odata_valid && ((r_count != FULL_CNT) || w_retire);
  assign w_drop     = (r_state == RUN) && odata_valid && (r_count == FULL_CNT) && !w_retire;
  assign w_job_done = w_retire && ((r_frames_out + 16'd1) == r_frame_total);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (active) w_state_next = (frame_total == 16'd0) ? DONE : RUN;
      RUN:        if (w_job_done) w_state_next = DONE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_beat_idx    <= '0;
      r_frame_total <= '0;
      r_frames_out  <= '0;
      r_overflow    <= 1'b0;
    end else if (w_start) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_beat_idx    <= '0;
      r_frame_total <= frame_total;
      r_frames_out  <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);

      if (w_retire) begin
        r_rptr       <= r_rptr + PW'(1);
        r_beat_idx   <= '0;
        r_frames_out <= r_frames_out + 16'd1;
      end else if (w_xfer) begin
        r_beat_idx   <= r_beat_idx + NBW'(1);
      end

      if (w_push && !w_retire)      r_count <= r_count + CW'(1);
      else if (!w_push && w_retire) r_count <= r_count - CW'(1);

      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // NOTE: slot storage has no reset; the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_slot[r_wptr]    <= odata;
      r_slot_nb[r_wptr] <= w_nb_in;
    end
  end

endmodule

// File: tb/tb_uds_out_serializer.sv
// Randomised and directed bench for uds_out_serializer: a frame-level reference
// model fills a beat scoreboard that a negedge monitor drains and compares.
module tb_uds_out_serializer;

  localparam int A      = 64;
  localparam int DW     = 32;
  localparam int BEAT   = 8;
  localparam int DEPTH  = 2;
  localparam int FW     = 2 * A * DW;
  localparam int BW     = BEAT * DW;

  logic            clk;
  logic            rst;
  logic            active;
  logic [15:0]     frame_total;
  logic [1:0]      function_mode;
  logic [1:0]      scale_factor;
  logic [FW-1:0]   odata;
  logic            odata_valid;
  logic [BW-1:0]   m_data;
  logic            m_valid;
  logic            m_last;
  logic            m_ready;
  logic            buf_full;
  logic            overflow;
  logic            finish;

  uds_out_serializer #(.A(A), .DW(DW), .BEAT(BEAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .active(active), .frame_total(frame_total),
    .function_mode(function_mode), .scale_factor(scale_factor),
    .odata(odata), .odata_valid(odata_valid),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .buf_full(buf_full), .overflow(overflow), .finish(finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit bp_mode   = 1'b0;
  bit rnd_ready = 1'b0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Reference model: job state, a queue of buffered frames (beats each) and expected beats.
  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
  typedef struct {
    logic [BW-1:0] data;
    bit            last;
  } beat_t;

  mstate_t md_state;
  int      md_total;
  int      md_out;
  int      md_beat;
  bit      md_ov;
  int      nb_q[$];
  beat_t   exp_q[$];

  always @(posedge clk or posedge rst) begin : model
    bit    mv;
    bit    retire;
    bit    push;
    int    n;
    int    nb;
    beat_t b;
    if (rst) begin
      md_state = M_IDLE;
      md_total = 0;
      md_out   = 0;
      md_beat  = 0;
      md_ov    = 1'b0;
      nb_q.delete();
      exp_q.delete();
    end else if (active && md_state != M_RUN) begin
      md_state = (frame_total == 16'd0) ? M_DONE : M_RUN;
      md_total = int'(frame_total);
      md_out   = 0;
      md_beat  = 0;
      md_ov    = 1'b0;
      nb_q.delete();
      exp_q.delete();
    end else if (md_state == M_RUN) begin
      mv     = nb_q.size() != 0;
      retire = mv && m_ready && (md_beat == nb_q[0] - 1);
      push   = odata_valid && (nb_q.size() < DEPTH || retire);
      if (odata_valid && !push) md_ov = 1'b1;
      if (retire) begin
        void'(nb_q.pop_front());
        md_beat = 0;
        md_out++;
        if (md_out == md_total) md_state = M_DONE;
      end else if (mv && m_ready) begin
        md_beat++;
      end
      if (push) begin
        n  = function_mode[0] ? (A >> scale_factor) : 2 * A;
        nb = n / BEAT;
        nb_q.push_back(nb);
        for (int k = 0; k < nb; k++) begin
          b.data = odata[k*BW +: BW];
          b.last = (k == nb - 1);
          exp_q.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    bit mv;
    if (!rst) begin
      mv = (md_state == M_RUN) && (nb_q.size() != 0);
      check1("m_valid", m_valid, mv);
      check1("buf_full", buf_full, nb_q.size() == DEPTH);
      check1("overflow", overflow, md_ov);
      check1("finish", finish, md_state == M_DONE);
      if (mv && exp_q.size() != 0) begin
        check("m_data", m_data, exp_q[0].data);
        check1("m_last", m_last, exp_q[0].last);
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bp_mode)        m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else if (rnd_ready) m_ready = ($urandom_range(3) != 0);
  endtask

  task automatic fill(input bit seq);
    for (int i = 0; i < 2 * A; i++) odata[i*DW +: DW] = seq ? DW'(i) : DW'($urandom());
  endtask

  task automatic start_job(input int total);
    frame_total = 16'(total);
    active      = 1'b1;
    tick();
    active      = 1'b0;
  endtask

  task automatic send(input logic [1:0] mode, input logic [1:0] sf, input bit seq);
    fill(seq);
    function_mode = mode;
    scale_factor  = sf;
    odata_valid   = 1'b1;
    tick();
    odata_valid   = 1'b0;
  endtask

  task automatic wait_finish(input int budget, input string name);
    int n = 0;
    while (!finish && n < budget) begin
      tick();
      n++;
    end
    check1(name, finish, 1'b1);
  endtask

  task automatic reset_checks(input string tag);
    check1({tag, "_m_valid"}, m_valid, 1'b0);
    check1({tag, "_m_last"}, m_last, 1'b0);
    check({tag, "_m_data"}, m_data, '0);
    check1({tag, "_buf_full"}, buf_full, 1'b0);
    check1({tag, "_overflow"}, overflow, 1'b0);
    check1({tag, "_finish"}, finish, 1'b0);
  endtask

  initial begin
    rst = 1'b1; active = 1'b0; frame_total = '0; function_mode = '0;
    scale_factor = '0; odata = '0; odata_valid = 1'b0; m_ready = 1'b1;
    repeat (2) tick();
    reset_checks("reset");
    rst = 1'b0;
    tick();

    // Upsample, ramp data, free-flowing sink.
    start_job(1);
    send(2'b00, 2'd0, 1'b1);
    wait_finish(40, "finish_up");

    // Downsample: one beat at sf=3, eight beats at sf=0.
    start_job(2);
    send(2'b01, 2'd3, 1'b1);
    send(2'b01, 2'd0, 1'b1);
    wait_finish(40, "finish_down");

    // Backpressure pattern 1,0,0,1 over two upsample frames.
    bp_mode = 1'b1;
    start_job(2);
    send(2'b00, 2'd0, 1'b0);
    send(2'b00, 2'd0, 1'b0);
    wait_finish(200, "finish_bp");
    check1("bp_overflow", overflow, 1'b0);
    bp_mode = 1'b0;
    m_ready = 1'b1;

    // Overflow: stalled sink, three frames back to back.
    m_ready = 1'b0;
    start_job(3);
    send(2'b00, 2'd0, 1'b0);
    send(2'b00, 2'd0, 1'b0);
    check1("ovf_buf_full", buf_full, 1'b1);
    send(2'b00, 2'd0, 1'b0);
    check1("ovf_overflow", overflow, 1'b1);
    m_ready = 1'b1;
    repeat (40) tick();
    check1("ovf_finish_early", finish, 1'b0);
    send(2'b00, 2'd0, 1'b0);
    wait_finish(40, "finish_ovf");

    // Push coinciding with the last-beat handshake of a full buffer.
    m_ready = 1'b0;
    start_job(3);
    send(2'b01, 2'd3, 1'b0);
    send(2'b01, 2'd3, 1'b0);
    m_ready = 1'b1;
    send(2'b01, 2'd3, 1'b0);
    check1("simul_overflow", overflow, 1'b0);
    check1("simul_buf_full", buf_full, 1'b1);
    wait_finish(20, "finish_simul");

    // Reset in the middle of beat 5, then a fresh one-frame job.
    start_job(1);
    send(2'b00, 2'd0, 1'b1);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    tick();
    reset_checks("midrst_next");
    rst = 1'b0;
    tick();
    start_job(1);
    send(2'b00, 2'd0, 1'b1);
    wait_finish(40, "finish_after_rst");

    // Random traffic, random sink readiness, drops allowed.
    rnd_ready = 1'b1;
    start_job(6);
    for (int n = 0; n < 3000 && !finish; n++) begin
      fill(1'b0);
      function_mode = 2'($urandom_range(3));
      scale_factor  = 2'($urandom_range(3));
      odata_valid   = ($urandom_range(3) == 0);
      tick();
    end
    odata_valid = 1'b0;
    check1("finish_random", finish, 1'b1);
    rnd_ready = 1'b0;
    m_ready   = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uds_out_serializer.md
Name: uds_out_serializer

Overview:
- Downstream consumer of the UDS upsample/downsample engine.
- Captures each wide UDS result vector (2*A words of DW bits) into a small frame buffer. UDS has no backpressure, so the buffer absorbs its output.
- Streams the valid words of each frame out as BEAT-word beats over a valid/ready interface to the memory writer.
- Counts frames and raises finish once the programmed number of frames has been emitted.

Parameters:
- A, 64: UDS input vector length in words; UDS output vector is 2*A words.
- DW, 32: word width in bits.
- BEAT, 8: words per output beat. Power of two, BEAT <= A/8.
- DEPTH, 2: frame buffer slots. Power of two, >= 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- active  in  1  one-cycle job start pulse.
- frame_total  in  16  frames expected for the job; sampled on active.
- function_mode  in  2  bit0: 0 = upsample, 1 = downsample; sampled per frame at capture.
- scale_factor  in  2  downsample shift; sampled per frame at capture.
- odata  in  2*A*DW  UDS result vector; word i at bits [i*DW +: DW].
- odata_valid  in  1  UDS result strobe, one frame per asserted cycle.
- m_data  out  BEAT*DW  output beat.
- m_valid  out  1  beat valid.
- m_last  out  1  last beat of current frame.
- m_ready  in  1  sink ready.
- buf_full  out  1  all DEPTH slots occupied.
- overflow  out  1  sticky: a frame was dropped.
- finish  out  1  level: frame_total frames emitted.

Behaviour:
- Reset values: m_valid=0, m_last=0, m_data=0, buf_full=0, overflow=0, finish=0. Reset also puts state=IDLE and clears all pointers and counters. Reset mid-frame discards buffer contents; no partial beat is emitted afterwards.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on active. active latches frame_total, clears frames_out, beat_idx, pointers, count and overflow.
  - RUN -> DONE on the cycle the last beat of frame number frame_total handshakes.
  - DONE -> RUN on active, with the same clears as IDLE -> RUN.
  - active in RUN is ignored.
  - frame_total=0: active goes straight to DONE.
- finish=1 exactly while state=DONE.
- Capture:
  - In RUN, odata_valid=1 with count<DEPTH writes odata plus that frame's word count N into slot wptr; wptr and count increment.
  - N is computed at capture: upsample N=2*A; downsample N=A>>scale_factor (sf=0 gives N=A).
  - Beats per frame NB = N/BEAT, always an integer.
  - odata_valid outside RUN is ignored.
- Overflow: odata_valid when count==DEPTH and no frame retires in the same cycle drops the frame and sets overflow. overflow stays set until rst or the next active.
- Simultaneous push and retire when full: both take effect, count unchanged, no overflow.
- Output:
  - m_valid = (state==RUN) && count!=0, from registered state.
  - A frame captured at edge t can present its first beat at t+1 (1-cycle latency).
  - m_data = slot[rptr] words beat_idx*BEAT .. beat_idx*BEAT+BEAT-1, lowest word in LSBs.
  - m_last = m_valid && beat_idx==NB-1.
- Handshake:
  - A beat transfers when m_valid && m_ready.
  - m_data and m_last hold stable while m_valid && !m_ready.
  - On transfer beat_idx increments. If it was the last beat: beat_idx=0, rptr increments, count decrements, frames_out increments.
  - Wrap-around: wptr and rptr wrap modulo DEPTH.
- buf_full = (count==DEPTH).
- Words above N in a slot are never emitted.

Test Plan:
- Reset mid-stream: assert rst during beat 5 of a frame -> all outputs 0 next cycle. Then active with frame_total=1 and one new frame -> beats start from beat 0.
- Upsample, A=64, BEAT=8, frame_total=1, m_ready=1: word i = i -> 16 beats, beat k carries words 8k..8k+7, m_last only on beat 15, first m_valid one cycle after odata_valid, finish=1 the cycle after beat 15.
- Downsample with scale_factor=3: N=8 -> single beat with words 0..7 and m_last=1. With scale_factor=0: 8 beats.
- Backpressure: m_ready toggles 1,0,0,1 repeating over 2 upsample frames -> m_data and m_last constant while stalled, 32 beats total, correct order, no overflow.
- Overflow: m_ready=0, DEPTH=2, three consecutive odata_valid -> buf_full=1 after the second, overflow=1 after the third. Releasing m_ready emits frames 1 and 2 only. finish never rises with frame_total=3 until another frame arrives.
- Simultaneous push and retire: buffer full, odata_valid coincides with the last-beat handshake -> frame accepted, overflow stays 0, count stays 2.
